wb_arbiter: RTL and testbench

//  Writeback stage that sits directly upstream of the register file write port.
//  - Merges single-cycle ALU results with buffered load returns from the LSU.
//  - Drives one registered (w_addr, din) write per cycle into the register file.
//  - Optionally tracks outstanding load destinations, so decode can stall on RAW hazards.
//

---
 rtl/wb_arbiter.sv | 77 +++++++
 tb/tb_wb_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter merging ALU results with queued load returns into one register file write per cycle
// Optional load-destination scoreboard enabled by defining WB_SCOREBOARD_EN.
module wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int LQ_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  alu_valid_i,
  input  logic [4:0]            alu_rd_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  output logic                  alu_stall_o,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [4:0]            lsu_rd_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  input  logic                  iss_load_i,
  input  logic [4:0]            iss_rd_i,
  input  logic [4:0]            chk_rs1_i,
  input  logic [4:0]            chk_rs2_i,
  output logic                  hazard_o,
  output logic [4:0]            w_addr_o,
  output logic [DATA_WIDTH-1:0] din_o
);
  localparam int AW = $clog2(LQ_DEPTH);
  localparam int CW = $clog2(LQ_DEPTH + 1);
  logic [4:0]            q_rd   [LQ_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [LQ_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, alu_req, alu_win, push, pop;
  logic [4:0]            head_rd;
  assign full        = count == CW'(LQ_DEPTH);
  assign lsu_ready_o = !full;
  assign alu_req     = alu_valid_i && alu_rd_i != 5'd0;
  assign alu_stall_o = full && alu_req;
  assign alu_win     = alu_req && !full;
  assign push        = lsu_valid_i && lsu_ready_o && lsu_rd_i != 5'd0;
  assign pop         = full || (!alu_req && count != '0);
  assign head_rd     = q_rd[rd_ptr];
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_rd[wr_ptr]   <= lsu_rd_i;
      q_data[wr_ptr] <= lsu_data_i;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      w_addr_o <= '0;
      din_o    <= '0;
    end else begin
      wr_ptr   <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr   <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count    <= count + CW'(push) - CW'(pop);
      w_addr_o <= alu_win ? alu_rd_i : pop ? head_rd : 5'd0;
      din_o    <= alu_win ? alu_data_i : pop ? q_data[rd_ptr] : '0;
    end
  end
`ifdef WB_SCOREBOARD_EN
  // Bit 0 is forced low so x0 can never report a hazard.
  logic [31:0] pending, set_mask, clr_mask;
  assign set_mask = iss_load_i ? 32'd1 << iss_rd_i : 32'd0;
  assign clr_mask = pop ? 32'd1 << head_rd : 32'd0;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pending <= '0;
    else pending <= ((pending & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
  end
  assign hazard_o = pending[chk_rs1_i] || pending[chk_rs2_i];
`else
  logic unused_sb;
  assign unused_sb = ^{iss_load_i, iss_rd_i, chk_rs1_i, chk_rs2_i};
  assign hazard_o  = 1'b0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0, iss_load = 1'b0;
  logic [4:0]  alu_rd = '0, lsu_rd = '0, iss_rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic        alu_stall, lsu_ready, hazard;
  logic [4:0]  w_addr;
  logic [31:0] din;
  int          errors = 0, checks = 0;
`ifdef WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif
  wb_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data), .alu_stall_o(alu_stall),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data),
    .iss_load_i(iss_load), .iss_rd_i(iss_rd), .chk_rs1_i(rs1), .chk_rs2_i(rs2),
    .hazard_o(hazard), .w_addr_o(w_addr), .din_o(din)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_addr"}, 32'(w_addr), 32'(a));
    chk({tag, "_din"}, din, d);
  endtask
  initial begin
    #12;
    wr("reset", 5'd0, 32'd0);
    chk("reset_ready", 32'(lsu_ready), 32'd1);
    chk("reset_stall", 32'(alu_stall), 32'd0);
    chk("reset_hazard", 32'(hazard), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick();
    wr("alu", 5'd5, 32'h1234);
    alu_valid = 1'b0;
    tick();
    wr("alu_idle", 5'd0, 32'd0);
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'hAA;
    #1 chk("load_ready", 32'(lsu_ready), 32'd1);
    tick();
    lsu_valid = 1'b0;
    wr("load_queued", 5'd0, 32'd0);
    tick();
    wr("load_pop", 5'd3, 32'hAA);
    tick();
    wr("load_idle", 5'd0, 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h11;
    tick();
    wr("mix_alu9", 5'd9, 32'h99);
    alu_rd = 5'd10; alu_data = 32'h100;
    lsu_rd = 5'd2; lsu_data = 32'h22;
    #1 chk("mix_stall1", 32'(alu_stall), 32'd0);
    tick();
    wr("mix_alu10", 5'd10, 32'h100);
    lsu_valid = 1'b0;
    alu_rd = 5'd11; alu_data = 32'h111;
    #1 chk("full_ready", 32'(lsu_ready), 32'd0);
    chk("full_stall", 32'(alu_stall), 32'd1);
    tick();
    wr("full_pop1", 5'd1, 32'h11);
    chk("after_ready", 32'(lsu_ready), 32'd1);
    chk("after_stall", 32'(alu_stall), 32'd0);
    tick();
    wr("alu_resume", 5'd11, 32'h111);
    alu_valid = 1'b0;
    tick();
    wr("pop2", 5'd2, 32'h22);
    tick();
    wr("mix_idle", 5'd0, 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hBEEF;
    #1 chk("rd0_stall", 32'(alu_stall), 32'd0);
    chk("rd0_ready", 32'(lsu_ready), 32'd1);
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    wr("rd0_w1", 5'd0, 32'd0);
    tick();
    wr("rd0_w2", 5'd0, 32'd0);
    iss_load = 1'b1; iss_rd = 5'd7; rs1 = 5'd7;
    tick();
    iss_load = 1'b0;
    chk("sb_set", 32'(hazard), 32'(SB));
    rs1 = 5'd0; rs2 = 5'd7;
    #1 chk("sb_rs2", 32'(hazard), 32'(SB));
    rs2 = 5'd0;
    #1 chk("sb_none", 32'(hazard), 32'd0);
    rs1 = 5'd7;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    tick();
    lsu_valid = 1'b0;
    chk("sb_queued", 32'(hazard), 32'(SB));
    iss_load = 1'b1;
    tick();
    iss_load = 1'b0;
    wr("sb_pop1", 5'd7, 32'h77);
    chk("sb_set_wins", 32'(hazard), 32'(SB));
    lsu_valid = 1'b1; lsu_data = 32'h78;
    tick();
    lsu_valid = 1'b0;
    tick();
    wr("sb_pop2", 5'd7, 32'h78);
    chk("sb_clear", 32'(hazard), 32'd0);
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
    tick();
    alu_rd = 5'd13; alu_data = 32'hD;
    lsu_rd = 5'd6; lsu_data = 32'h66;
    tick();
    wr("pre_rst", 5'd13, 32'hD);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    chk("pre_rst_full", 32'(lsu_ready), 32'd0);
    rst_n = 1'b0;
    #1 wr("rst_async", 5'd0, 32'd0);
    chk("rst_ready", 32'(lsu_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wr("post_rst1", 5'd0, 32'd0);
    tick();
    wr("post_rst2", 5'd0, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
